// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver: FSM state,
// scan codes, ASCII values and the make-code to letter lookup.
package kbd_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    DECODE = 3'd4
  } kbd_state_t;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_E     = 8'h24;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_F     = 8'h2B;
  localparam logic [7:0] SC_B     = 8'h32;
  localparam logic [7:0] SC_R     = 8'h2D;

  localparam logic [7:0] ASCII_E = 8'h45;
  localparam logic [7:0] ASCII_D = 8'h44;
  localparam logic [7:0] ASCII_F = 8'h46;
  localparam logic [7:0] ASCII_B = 8'h42;
  localparam logic [7:0] ASCII_R = 8'h52;

  // Debug view of the receiver FSM, exported on the top-level dbg port.
  typedef struct packed {
    kbd_state_t  state;
    logic [2:0]  bit_cnt;
    logic        tick;
    logic        brk;
    logic        ext;
  } kbd_dbg_t;

  // Returns {hit, ascii}; hit is 0 for codes without a letter mapping.
  function automatic logic [8:0] map_make(input logic [7:0] code);
    logic [8:0] res;
    res = 9'h000;
    case (code)
      SC_E:    res = {1'b1, ASCII_E};
      SC_D:    res = {1'b1, ASCII_D};
      SC_F:    res = {1'b1, ASCII_F};
      SC_B:    res = {1'b1, ASCII_B};
      SC_R:    res = {1'b1, ASCII_R};
      default: res = 9'h000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// Synchronizes the raw PS/2 lines, debounces ps2_clk and emits a one-cycle
// tick on each filtered falling edge.
module ps2_filter
  import kbd_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_sync,
  output logic tick
);

  localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync_q;
  logic          clk_s;
  logic          clk_filt;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync    <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync    <= {clk_sync[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
    end
  end

  assign clk_s     = clk_sync[1];
  assign data_sync = data_sync_q[1];

  // cnt counts consecutive samples that disagree with the filtered level;
  // any agreeing sample restarts the run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_filt <= 1'b1;
      cnt      <= '0;
      tick     <= 1'b0;
    end else if (clk_s == clk_filt) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(FILTER_LEN - 1)) begin
      clk_filt <= clk_s;
      cnt      <= '0;
      tick     <= clk_filt;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: frames 11-bit PS/2 packets, checks odd parity and
// stop bit, tracks break/extended prefixes and maps five make codes to ASCII.
module ps2_kbd_rx
  import kbd_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] letter,
  output logic       kbd_ready,
  output logic       frame_err,
  output kbd_dbg_t   dbg
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // kbd_ready is a qualifier pulse with no back-pressure: letter is valid
  // from the pulse cycle and holds until the next pulse or reset.

  logic          tick;
  logic          data_s;

  kbd_state_t    state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    code, code_n;
  logic          par_ok, par_ok_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic          brk, brk_n;
  logic          ext, ext_n;
  logic [7:0]    letter_n;
  logic          ready_n;
  logic          err_n;
  logic [8:0]    mapped;

  ps2_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk      (clk),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .data_sync(data_s),
    .tick     (tick)
  );

  assign mapped = map_make(code);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      code      <= '0;
      par_ok    <= 1'b0;
      to_cnt    <= '0;
      brk       <= 1'b0;
      ext       <= 1'b0;
      letter    <= 8'h00;
      kbd_ready <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      code      <= code_n;
      par_ok    <= par_ok_n;
      to_cnt    <= to_cnt_n;
      brk       <= brk_n;
      ext       <= ext_n;
      letter    <= letter_n;
      kbd_ready <= ready_n;
      frame_err <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    code_n    = code;
    par_ok_n  = par_ok;
    to_cnt_n  = '0;
    brk_n     = brk;
    ext_n     = ext;
    letter_n  = letter;
    ready_n   = 1'b0;
    err_n     = 1'b0;

    case (state)
      IDLE: begin
        if (tick && !data_s) begin
          state_n   = DATA;
          bit_cnt_n = 3'd0;
        end
      end

      DATA, PARITY, STOP: begin
        if (tick) begin
          if (state == DATA) begin
            code_n    = {data_s, code[7:1]};
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state_n = PARITY;
          end else if (state == PARITY) begin
            // Odd parity: data bits plus the parity bit hold an odd number of ones.
            par_ok_n = ^{code, data_s};
            state_n  = STOP;
          end else if (data_s && par_ok) begin
            state_n = DECODE;
          end else begin
            state_n = IDLE;
            err_n   = 1'b1;
            brk_n   = 1'b0;
            ext_n   = 1'b0;
          end
        end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state_n = IDLE;
          err_n   = 1'b1;
          brk_n   = 1'b0;
          ext_n   = 1'b0;
        end else begin
          to_cnt_n = to_cnt + TW'(1);
        end
      end

      DECODE: begin
        state_n = IDLE;
        if (code == SC_BREAK) begin
          brk_n = 1'b1;
        end else if (code == SC_EXT) begin
          ext_n = 1'b1;
        end else if (brk || ext) begin
          // Released or extended key: swallow it and drop both prefixes.
          brk_n = 1'b0;
          ext_n = 1'b0;
        end else if (mapped[8]) begin
          letter_n = mapped[7:0];
          ready_n  = 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign dbg = '{state: state, bit_cnt: bit_cnt, tick: tick, brk: brk, ext: ext};

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: directed scenarios plus a randomized
// frame stream checked against a behavioural keyboard model.
module tb_ps2_kbd_rx;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 1500;
  localparam int HALF           = 30;

  logic clk      = 1'b0;
  logic reset_n  = 1'b0;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;
  logic [7:0] letter;
  logic       kbd_ready;
  logic       frame_err;
  kbd_pkg::kbd_dbg_t dbg;

  int checks   = 0;
  int failures = 0;

  // monitor-owned observations
  int cycle       = 0;
  int last_tick   = 0;
  int ready_cnt   = 0;
  int err_cnt     = 0;
  int overlap_cnt = 0;
  int wide_cnt    = 0;
  logic prev_ready = 1'b0;
  logic prev_err   = 1'b0;
  logic [7:0] got_q[$];
  int         lat_q[$];

  // reference model state
  logic [7:0] exp_q[$];
  logic [7:0] m_letter;
  bit         m_brk;
  bit         m_ext;
  int         exp_err;
  int         got_rd;

  always #5 clk = ~clk;

  ps2_kbd_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .letter   (letter),
    .kbd_ready(kbd_ready),
    .frame_err(frame_err),
    .dbg      (dbg)
  );

  always @(negedge clk) begin
    cycle = cycle + 1;
    if (dbg.tick) last_tick = cycle;
    if (kbd_ready) begin
      ready_cnt = ready_cnt + 1;
      got_q.push_back(letter);
      lat_q.push_back(cycle - last_tick);
    end
    if (frame_err) err_cnt = err_cnt + 1;
    if (kbd_ready && frame_err) overlap_cnt = overlap_cnt + 1;
    if ((kbd_ready && prev_ready) || (frame_err && prev_err)) wide_cnt = wide_cnt + 1;
    prev_ready = kbd_ready;
    prev_err   = frame_err;
  end

  // ---------------- model ----------------
  task automatic model_code(input logic [7:0] c);
    logic [7:0] a;
    a = 8'h00;
    if (c == 8'hF0) m_brk = 1'b1;
    else if (c == 8'hE0) m_ext = 1'b1;
    else if (m_brk || m_ext) begin
      m_brk = 1'b0;
      m_ext = 1'b0;
    end else begin
      case (c)
        8'h24: a = "E";
        8'h23: a = "D";
        8'h2B: a = "F";
        8'h32: a = "B";
        8'h2D: a = "R";
        default: a = 8'h00;
      endcase
      if (a != 8'h00) begin
        exp_q.push_back(a);
        m_letter = a;
      end
    end
  endtask

  task automatic model_bad();
    exp_err = exp_err + 1;
    m_brk   = 1'b0;
    m_ext   = 1'b0;
  endtask

  // ---------------- drivers ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int gl);
    ps2_data = b;
    if (gl > 0) begin
      wait_cyc(8); ps2_clk = 1'b0; wait_cyc(gl); ps2_clk = 1'b1; wait_cyc(HALF - 8 - gl);
    end else wait_cyc(HALF);
    ps2_clk = 1'b0;
    if (gl > 0) begin
      wait_cyc(8); ps2_clk = 1'b1; wait_cyc(gl); ps2_clk = 1'b0; wait_cyc(HALF - 8 - gl);
    end else wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                            input bit glitch);
    logic p;
    p = ~(^code) ^ bad_par;
    send_bit(1'b0, glitch ? $urandom_range(FILTER_LEN - 2, 1) : 0);
    for (int i = 0; i < 8; i++) send_bit(code[i], glitch ? $urandom_range(FILTER_LEN - 2, 1) : 0);
    send_bit(p, glitch ? $urandom_range(FILTER_LEN - 2, 1) : 0);
    send_bit(~bad_stop, 0);
    ps2_data = 1'b1;
    wait_cyc(20);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    wait_cyc(3);
    checks++; if (letter !== 8'h00) begin failures++; $display("FAIL reset_letter: got %h want 00", letter); end
    checks++; if (kbd_ready !== 1'b0 || frame_err !== 1'b0) begin
      failures++; $display("FAIL reset_pulses: ready=%b err=%b want 0 0", kbd_ready, frame_err); end
    checks++; if (dbg.state !== kbd_pkg::IDLE) begin failures++; $display("FAIL reset_state: got %0d want IDLE", dbg.state); end
    reset_n = 1'b1;
    wait_cyc(40);
    checks++; if (ready_cnt !== 0 || err_cnt !== 0) begin
      failures++; $display("FAIL reset_quiet: ready=%0d err=%0d want 0 0", ready_cnt, err_cnt); end
  endtask

  task automatic test_letter_e();
    int r0;
    r0 = ready_cnt;
    send_frame(8'h24, 0, 0, 0);
    checks++; if (ready_cnt - r0 !== 1) begin failures++; $display("FAIL e_count: got %0d pulses want 1", ready_cnt - r0); end
    checks++; if (letter !== 8'h45) begin failures++; $display("FAIL e_letter: got %h want 45", letter); end
    checks++; if (lat_q.size() == 0 || lat_q[lat_q.size() - 1] !== 2) begin
      failures++; $display("FAIL e_latency: got %0d want 2", lat_q.size() == 0 ? -1 : lat_q[lat_q.size() - 1]); end
    checks++; if (wide_cnt !== 0 || err_cnt !== 0) begin
      failures++; $display("FAIL e_clean: wide=%0d err=%0d want 0 0", wide_cnt, err_cnt); end
  endtask

  task automatic test_break_seq();
    int r0;
    r0 = ready_cnt;
    send_frame(8'h2D, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h2D, 0, 0, 0);
    checks++; if (ready_cnt - r0 !== 1) begin failures++; $display("FAIL break_count: got %0d pulses want 1", ready_cnt - r0); end
    checks++; if (letter !== 8'h52) begin failures++; $display("FAIL break_letter: got %h want 52", letter); end
  endtask

  task automatic test_parity_err();
    int r0, e0;
    r0 = ready_cnt; e0 = err_cnt;
    send_frame(8'h2B, 1, 0, 0);
    checks++; if (err_cnt - e0 !== 1 || ready_cnt !== r0) begin
      failures++; $display("FAIL parity_err: err=%0d ready=%0d want 1 0", err_cnt - e0, ready_cnt - r0); end
    checks++; if (letter !== 8'h52) begin failures++; $display("FAIL parity_hold: got %h want 52", letter); end
    send_frame(8'h32, 0, 0, 0);
    checks++; if (letter !== 8'h42 || ready_cnt - r0 !== 1) begin
      failures++; $display("FAIL parity_recover: letter=%h ready=%0d want 42 1", letter, ready_cnt - r0); end
  endtask

  task automatic test_extended();
    int r0;
    r0 = ready_cnt;
    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'h24, 0, 0, 0);
    checks++; if (ready_cnt !== r0 || letter !== 8'h42) begin
      failures++; $display("FAIL ext_swallow: ready=%0d letter=%h want 0 42", ready_cnt - r0, letter); end
    send_frame(8'h23, 0, 0, 0);
    checks++; if (letter !== 8'h44 || ready_cnt - r0 !== 1) begin
      failures++; $display("FAIL ext_after: letter=%h ready=%0d want 44 1", letter, ready_cnt - r0); end
  endtask

  task automatic test_timeout();
    int r0, e0;
    r0 = ready_cnt; e0 = err_cnt;
    send_bit(1'b0, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    ps2_data = 1'b1;
    wait_cyc(TIMEOUT_CYCLES + 200);
    checks++; if (err_cnt - e0 !== 1 || ready_cnt !== r0) begin
      failures++; $display("FAIL timeout_err: err=%0d ready=%0d want 1 0", err_cnt - e0, ready_cnt - r0); end
    checks++; if (dbg.state !== kbd_pkg::IDLE) begin failures++; $display("FAIL timeout_state: got %0d want IDLE", dbg.state); end
    send_frame(8'h24, 0, 0, 0);
    checks++; if (letter !== 8'h45 || ready_cnt - r0 !== 1) begin
      failures++; $display("FAIL timeout_recover: letter=%h ready=%0d want 45 1", letter, ready_cnt - r0); end
  endtask

  task automatic test_glitch();
    int r0, e0;
    r0 = ready_cnt; e0 = err_cnt;
    send_frame(8'h32, 0, 0, 1);
    checks++; if (letter !== 8'h42 || ready_cnt - r0 !== 1 || err_cnt !== e0) begin
      failures++; $display("FAIL glitch: letter=%h ready=%0d err=%0d want 42 1 0", letter, ready_cnt - r0, err_cnt - e0); end
  endtask

  task automatic test_reset_mid();
    int r0, e0;
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(i[0], 0);
    reset_n = 1'b0;
    wait_cyc(2);
    checks++; if (letter !== 8'h00 || kbd_ready !== 1'b0 || frame_err !== 1'b0) begin
      failures++; $display("FAIL midreset_force: letter=%h ready=%b err=%b want 00 0 0", letter, kbd_ready, frame_err); end
    ps2_clk = 1'b1; ps2_data = 1'b1;
    wait_cyc(5);
    reset_n = 1'b1;
    r0 = ready_cnt; e0 = err_cnt;
    wait_cyc(TIMEOUT_CYCLES / 4);
    checks++; if (ready_cnt !== r0 || err_cnt !== e0 || letter !== 8'h00) begin
      failures++; $display("FAIL midreset_quiet: ready=%0d err=%0d letter=%h want 0 0 00", ready_cnt - r0, err_cnt - e0, letter); end
    send_frame(8'h1C, 0, 0, 0);
    checks++; if (ready_cnt !== r0 || letter !== 8'h00) begin
      failures++; $display("FAIL unmapped: ready=%0d letter=%h want 0 00", ready_cnt - r0, letter); end
    send_frame(8'h2B, 0, 0, 0);
    checks++; if (letter !== 8'h46 || ready_cnt - r0 !== 1) begin
      failures++; $display("FAIL midreset_next: letter=%h ready=%0d want 46 1", letter, ready_cnt - r0); end
  endtask

  task automatic test_random_stream();
    logic [7:0] pool[7];
    logic [7:0] c, prev;
    bit bp, bs;
    int e0, l0;
    pool[0] = 8'h24; pool[1] = 8'h23; pool[2] = 8'h2B; pool[3] = 8'h32;
    pool[4] = 8'h2D; pool[5] = 8'hF0; pool[6] = 8'hE0;
    m_letter = 8'h46; m_brk = 1'b0; m_ext = 1'b0; exp_err = 0;
    exp_q.delete();
    got_rd = got_q.size();
    l0 = lat_q.size();
    e0 = err_cnt;
    prev = 8'h24;
    for (int n = 0; n < 26; n++) begin
      if ($urandom_range(9, 0) < 3) c = prev;
      else if ($urandom_range(4, 0) == 0) c = 8'($urandom_range(255, 0));
      else c = pool[$urandom_range(6, 0)];
      bp = ($urandom_range(7, 0) == 0);
      bs = ($urandom_range(9, 0) == 0);
      send_frame(c, bp, bs, $urandom_range(3, 0) == 0);
      if (bp || bs) model_bad();
      else model_code(c);
      prev = c;
    end
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      checks++;
      if (got_rd >= got_q.size()) begin
        failures++; $display("FAIL stream_missing: no pulse left, want letter %h", c);
      end else begin
        if (got_q[got_rd] !== c) begin failures++; $display("FAIL stream_letter: got %h want %h", got_q[got_rd], c); end
        got_rd++;
      end
    end
    checks++; if (got_rd != got_q.size()) begin
      failures++; $display("FAIL stream_extra: %0d unexpected pulses", got_q.size() - got_rd); end
    checks++; if (err_cnt - e0 !== exp_err) begin failures++; $display("FAIL stream_err: got %0d want %0d", err_cnt - e0, exp_err); end
    checks++; if (letter !== m_letter) begin failures++; $display("FAIL stream_hold: got %h want %h", letter, m_letter); end
    for (int i = l0; i < lat_q.size(); i++) begin
      checks++; if (lat_q[i] !== 2) begin failures++; $display("FAIL stream_latency: got %0d want 2", lat_q[i]); end
    end
    checks++; if (overlap_cnt !== 0 || wide_cnt !== 0) begin
      failures++; $display("FAIL pulse_shape: overlap=%0d wide=%0d want 0 0", overlap_cnt, wide_cnt); end
  endtask

  initial begin
    test_reset();
    test_letter_e();
    test_break_seq();
    test_parity_err();
    test_extended();
    test_timeout();
    test_glitch();
    test_reset_mid();
    test_random_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_rx.md
PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive equal system-clock samples required to accept a new ps2_clk level.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000: system clocks without a filtered ps2_clk falling edge before an in-progress frame is aborted.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 ps2_clk  input  1  raw PS/2 clock from keyboard, asynchronous, idles high.
REQ-006 ps2_data  input  1  raw PS/2 data from keyboard, asynchronous, idles high.
REQ-007 letter  output  8  uppercase ASCII of the last accepted key.
REQ-008 kbd_ready  output  1  one-cycle pulse: letter has just been updated.
REQ-009 frame_err  output  1  one-cycle pulse: frame discarded (parity, stop or timeout).

Function
REQ-010 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any use.
REQ-011 Filtered clock SHALL change only after FILTER_LEN consecutive equal synchronized samples; a sample tick SHALL occur on each filtered 1->0 transition.
REQ-012 FSM states SHALL be IDLE, DATA, PARITY, STOP, DECODE; transitions advance only on sample ticks, except DECODE.
REQ-013 IDLE: tick with data=0 -> DATA, bit count 0; tick with data=1 -> stay IDLE, no error.
REQ-014 DATA: shift 8 bits LSB first into the code register; after bit 7 -> PARITY.
REQ-015 PARITY: data bits plus parity bit SHALL have odd count of ones; mismatch recorded, -> STOP.
REQ-016 STOP: data=1 and parity OK -> DECODE; otherwise frame_err pulse next cycle, -> IDLE.
REQ-017 DECODE lasts exactly one cycle, then -> IDLE.
REQ-018 Code 0xF0 SHALL set a break flag; code 0xE0 SHALL set an extended flag; neither produces output.
REQ-019 Any other code with break or extended flag set SHALL produce no output and SHALL clear both flags.
REQ-020 Make codes with both flags clear SHALL map: 0x24->0x45 'E', 0x23->0x44 'D', 0x2B->0x46 'F', 0x32->0x42 'B', 0x2D->0x52 'R'.
REQ-021 For a mapped make code, letter SHALL update and kbd_ready SHALL pulse high for one cycle, both in the cycle after DECODE (2 cycles after the stop-bit tick).
REQ-022 Unmapped make codes SHALL produce no pulse and leave letter unchanged.
REQ-023 letter SHALL hold its value between updates; repeated (typematic) make codes SHALL each pulse kbd_ready.
REQ-024 In DATA, PARITY or STOP, TIMEOUT_CYCLES clocks without a tick SHALL abort to IDLE with a frame_err pulse; timeout counter SHALL clear on every tick and in IDLE.
REQ-025 Any frame_err SHALL also clear break and extended flags.
REQ-026 kbd_ready and frame_err SHALL never be high in the same cycle.

Reset
REQ-027 reset_n low SHALL immediately force: FSM IDLE, letter 0x00, kbd_ready 0, frame_err 0, flags clear, counters 0, synchronizers and filtered clock 1.
REQ-028 Reset mid-frame SHALL discard the partial frame; the first post-reset output SHALL need a complete new frame.

Structure
REQ-029 Package kbd_pkg SHALL hold the FSM state enum, scan-code constants (0xF0, 0xE0, the five make codes) and ASCII constants 0x45/0x44/0x46/0x42/0x52.
REQ-030 Sub-module ps2_filter SHALL contain the synchronizers, FILTER_LEN debounce and falling-edge tick; ps2_kbd_rx instantiates it once.

Verification
REQ-031 Frame 0x24, parity 1, stop 1 -> letter 0x45, single-cycle kbd_ready 2 clocks after stop tick.
REQ-032 Sequence 0x2D, 0xF0, 0x2D -> exactly one kbd_ready pulse, letter 0x52.
REQ-033 Frame 0x2B with parity 0 -> frame_err one pulse, no kbd_ready, letter unchanged; next good 0x32 -> letter 0x42.
REQ-034 Sequence 0xE0, 0x24 then 0x23 -> no output for 0x24, then letter 0x44 with pulse.
REQ-035 Start bit plus 3 data bits, then idle clock >TIMEOUT_CYCLES -> frame_err pulse, FSM IDLE; next full 0x24 frame -> letter 0x45.
REQ-036 ps2_clk glitches shorter than FILTER_LEN during frame 0x32 -> letter 0x42, no frame_err; reset_n low mid-frame -> letter 0x00, no pulse until next full frame.
